// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator engine: key op codes, FSM states,
// pending-operation encoding and 16-bit signed saturation helpers.
package calc_pkg;

  localparam logic [2:0] OP_DIGIT = 3'b000;
  localparam logic [2:0] OP_NEG   = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [2:0] OP_CLR   = 3'b110;

  localparam logic [15:0] MAX_S16 = 16'h7FFF;
  localparam logic [15:0] MIN_S16 = 16'h8000;

  typedef enum logic [1:0] {StWaitKey, StRelease, StExec, StMult} state_e;
  typedef enum logic [1:0] {PendNone, PendAdd, PendSub, PendMul} pend_e;

  // Clamp a 17-bit signed value to 16 bits; returns {overflow, value}.
  function automatic logic [16:0] sat17(input logic [16:0] v);
    if (v[16] != v[15]) return {1'b1, (v[16] ? MIN_S16 : MAX_S16)};
    return {1'b0, v[15:0]};
  endfunction

endpackage

// File: rtl/calc_mult16.sv
// Sequential 16x16 signed multiplier: shift-add over operand magnitudes, one bit per
// cycle, 16 cycles from start; sign and saturation applied as the last bit is added.
module calc_mult16
  import calc_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        done,
  output logic [15:0] result,
  output logic        ovf
);

  logic        busy_q, neg_q;
  logic [3:0]  cnt_q;
  logic [15:0] mcand_q, mplier_q;
  logic [31:0] prod_q, prod_next;
  logic [15:0] mag_a, mag_b, low;

  always_comb begin
    mag_a     = a[15] ? (~a + 16'd1) : a;
    mag_b     = b[15] ? (~b + 16'd1) : b;
    prod_next = prod_q + (mplier_q[0] ? ({16'd0, mcand_q} << cnt_q) : 32'd0);
    done      = busy_q && (cnt_q == 4'd15);
    low       = prod_next[15:0];
    // A negative result may reach -32768, one step further than the positive side.
    if (neg_q) begin
      ovf    = prod_next > 32'd32768;
      result = ovf ? MIN_S16 : (~low + 16'd1);
    end else begin
      ovf    = prod_next > 32'd32767;
      result = ovf ? MAX_S16 : low;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      busy_q   <= 1'b0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      neg_q    <= a[15] ^ b[15];
      cnt_q    <= '0;
      mcand_q  <= mag_a;
      mplier_q <= mag_b;
      prod_q   <= '0;
    end else if (busy_q) begin
      prod_q   <= prod_next;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 4'd1;
      if (cnt_q == 4'd15) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_engine.sv
// Calculator engine: accepts keypad events over the KeyRdy/KeyRd handshake, builds signed
// decimal operands and evaluates add/sub/mul/negate/clear with 16-bit saturation.
module calc_engine
  import calc_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        KeyRdy,
  output logic        KeyRd,
  input  logic [3:0]  Number,
  input  logic [2:0]  Operator,
  input  logic        EqualSign,
  output logic [15:0] Display,
  output logic [15:0] Result,
  output logic        ResultValid,
  output logic        Overflow
);

  state_e      state_q;
  pend_e       pend_q, next_op_q, key_pend;
  logic [15:0] acc_q, entry_q;
  logic        entry_active_q, valid_q, ovf_q, key_rd_q;
  logic [3:0]  key_num_q;
  logic [2:0]  key_op_q;
  logic        key_eq_q;

  logic [15:0] opb, neg_src;
  logic [16:0] wide, arith, neg_res;
  logic [20:0] base21, times10, digit21;
  logic        digit_ok, is_arith, addsub_pend, mul_start;
  logic        mul_done, mul_ovf;
  logic [15:0] mul_res;

  always_comb begin
    opb         = entry_active_q ? entry_q : 16'd0;
    addsub_pend = (pend_q == PendAdd) || (pend_q == PendSub);
    wide = (pend_q == PendSub) ? ({acc_q[15], acc_q} - {opb[15], opb})
                               : ({acc_q[15], acc_q} + {opb[15], opb});
    arith = sat17(wide);
    // Digit append: magnitude grows away from zero, so subtract on a negative entry.
    base21   = entry_active_q ? {{5{entry_q[15]}}, entry_q} : 21'd0;
    times10  = (base21 << 3) + (base21 << 1);
    digit21  = base21[20] ? (times10 - {17'd0, key_num_q}) : (times10 + {17'd0, key_num_q});
    digit_ok = (key_num_q <= 4'd9) && ((&digit21[20:15]) || !(|digit21[20:15]));
    neg_src  = entry_active_q ? entry_q : acc_q;
    neg_res  = (neg_src == MIN_S16) ? {1'b1, MAX_S16} : {1'b0, ~neg_src + 16'd1};
    case (key_op_q)
      OP_ADD:  key_pend = PendAdd;
      OP_SUB:  key_pend = PendSub;
      OP_MUL:  key_pend = PendMul;
      default: key_pend = PendNone;
    endcase
    is_arith  = !key_eq_q && (key_pend != PendNone);
    mul_start = (state_q == StExec) && (pend_q == PendMul) &&
                (key_eq_q || (is_arith && entry_active_q));
  end

  calc_mult16 u_mult (
    .Clock  (Clock),
    .Reset  (Reset),
    .start  (mul_start),
    .a      (acc_q),
    .b      (opb),
    .done   (mul_done),
    .result (mul_res),
    .ovf    (mul_ovf)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q        <= StWaitKey;
      pend_q         <= PendNone;
      next_op_q      <= PendNone;
      acc_q          <= '0;
      entry_q        <= '0;
      entry_active_q <= 1'b0;
      valid_q        <= 1'b0;
      ovf_q          <= 1'b0;
      key_rd_q       <= 1'b0;
      key_num_q      <= '0;
      key_op_q       <= '0;
      key_eq_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StWaitKey: if (KeyRdy) begin
          key_num_q <= Number;
          key_op_q  <= Operator;
          key_eq_q  <= EqualSign;
          key_rd_q  <= 1'b1;
          state_q   <= StRelease;
        end
        StRelease: if (!KeyRdy) begin
          key_rd_q <= 1'b0;
          state_q  <= StExec;
        end
        StExec: begin
          state_q <= mul_start ? StMult : StWaitKey;
          if (key_eq_q) begin
            if (addsub_pend) begin
              acc_q <= arith[15:0];
              ovf_q <= ovf_q | arith[16];
            end else if (pend_q == PendNone && entry_active_q) begin
              acc_q <= entry_q;
            end
            // A multiply in flight keeps PendMul until it lands, then takes next_op_q.
            pend_q         <= mul_start ? pend_q : PendNone;
            next_op_q      <= PendNone;
            entry_active_q <= 1'b0;
            valid_q        <= 1'b1;
          end else if (is_arith) begin
            if (entry_active_q && addsub_pend) begin
              acc_q <= arith[15:0];
              ovf_q <= ovf_q | arith[16];
            end else if (entry_active_q && pend_q == PendNone) begin
              acc_q <= entry_q;
            end
            pend_q         <= mul_start ? pend_q : key_pend;
            next_op_q      <= key_pend;
            entry_q        <= '0;
            entry_active_q <= 1'b0;
          end else if (key_op_q == OP_NEG) begin
            if (entry_active_q) entry_q <= neg_res[15:0];
            else                acc_q   <= neg_res[15:0];
            ovf_q <= ovf_q | neg_res[16];
          end else if (key_op_q == OP_CLR) begin
            acc_q          <= '0;
            entry_q        <= '0;
            entry_active_q <= 1'b0;
            pend_q         <= PendNone;
            next_op_q      <= PendNone;
            valid_q        <= 1'b0;
            ovf_q          <= 1'b0;
          end else if (key_op_q == OP_DIGIT && digit_ok) begin
            entry_q        <= digit21[15:0];
            entry_active_q <= 1'b1;
            valid_q        <= 1'b0;
          end
        end
        StMult: if (mul_done) begin
          acc_q   <= mul_res;
          ovf_q   <= ovf_q | mul_ovf;
          pend_q  <= next_op_q;
          state_q <= StWaitKey;
        end
        default: state_q <= StWaitKey;
      endcase
    end
  end

  assign KeyRd       = key_rd_q;
  assign Display     = entry_active_q ? entry_q : acc_q;
  assign Result      = acc_q;
  assign ResultValid = valid_q;
  assign Overflow    = ovf_q;

endmodule

// File: tb/tb_calc_engine.sv
// Self-checking bench for calc_engine: key sequences drive the handshake, expected
// displays are queued as keys are driven and compared as the engine settles.
module tb_calc_engine;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        KeyRdy = 1'b0;
  logic        KeyRd;
  logic [3:0]  Number = '0;
  logic [2:0]  Operator = '0;
  logic        EqualSign = 1'b0;
  logic [15:0] Display, Result;
  logic        ResultValid, Overflow;

  int          total = 0;
  int          passed = 0;
  int          pulses = 0;
  logic        kr_prev = 1'b0;
  logic [15:0] sb[$];
  logic [15:0] obs[$];

  calc_engine dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .KeyRdy      (KeyRdy),
    .KeyRd       (KeyRd),
    .Number      (Number),
    .Operator    (Operator),
    .EqualSign   (EqualSign),
    .Display     (Display),
    .Result      (Result),
    .ResultValid (ResultValid),
    .Overflow    (Overflow)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    kr_prev <= KeyRd;
    if (KeyRd && !kr_prev) pulses <= pulses + 1;
  end

  // Key chars: 0-9 digit, # negate, A add, B sub, * mul, C equals, D clear,
  // X Number=12, Y op 101, Z op 111. lat = edges until KeyRd rises.
  task automatic press(input byte c, output int lat);
    logic [3:0] n;
    logic [2:0] o;
    logic       e;
    int         w;
    n = '0; o = '0; e = 1'b0;
    case (c)
      "#": o = 3'b001;
      "A": o = 3'b010;
      "B": o = 3'b011;
      "*": o = 3'b100;
      "D": o = 3'b110;
      "C": e = 1'b1;
      "X": n = 4'd12;
      "Y": o = 3'b101;
      "Z": o = 3'b111;
      default: n = 4'(c - 8'd48);
    endcase
    Number = n; Operator = o; EqualSign = e; KeyRdy = 1'b1;
    lat = 0;
    while (KeyRd !== 1'b1 && lat < 40) begin
      @(posedge Clock); #1; lat++;
    end
    if (KeyRd !== 1'b1) begin
      total++;
      $display("FAIL keyrd_rise key=%s got=%b want=1", c, KeyRd);
    end
    KeyRdy = 1'b0;
    Number = 4'($urandom); Operator = 3'($urandom); EqualSign = 1'($urandom);
    w = 0;
    while (KeyRd !== 1'b0 && w < 40) begin
      @(posedge Clock); #1; w++;
    end
    if (KeyRd !== 1'b0) begin
      total++;
      $display("FAIL keyrd_fall key=%s got=%b want=0", c, KeyRd);
    end
  endtask

  task automatic drive_seq(input string keys);
    int lat;
    for (int i = 0; i < keys.len(); i++) begin
      press(keys[i], lat);
      repeat (20) @(posedge Clock);
      #1;
      obs.push_back(Display);
    end
  endtask

  task automatic test_reset(input string tag);
    @(posedge Clock); #1;
    Reset = 1'b0;
    #2;
    total += 5;
    if (KeyRd !== 1'b0) $display("FAIL %s_keyrd got=%b want=0", tag, KeyRd); else passed++;
    if (Display !== 16'h0) $display("FAIL %s_display got=%h want=0000", tag, Display);
    else passed++;
    if (Result !== 16'h0) $display("FAIL %s_result got=%h want=0000", tag, Result); else passed++;
    if (ResultValid !== 1'b0) $display("FAIL %s_valid got=%b want=0", tag, ResultValid);
    else passed++;
    if (Overflow !== 1'b0) $display("FAIL %s_ovf got=%b want=0", tag, Overflow); else passed++;
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_add;
    logic [15:0] got, exp;
    int          p0;
    p0 = pulses;
    sb = '{16'd1, 16'd12, 16'd123, 16'd123, 16'd4, 16'd45, 16'd168};
    drive_seq("123A45C");
    total += 4;
    if (Result !== 16'd168) $display("FAIL add_result got=%h want=%h", Result, 16'd168);
    else passed++;
    if (ResultValid !== 1'b1) $display("FAIL add_valid got=%b want=1", ResultValid); else passed++;
    if (Overflow !== 1'b0) $display("FAIL add_ovf got=%b want=0", Overflow); else passed++;
    if (pulses - p0 !== 7) $display("FAIL add_pulses got=%0d want=7", pulses - p0); else passed++;
    while (sb.size() != 0) begin
      got = obs.pop_front(); exp = sb.pop_front(); total++;
      if (got !== exp) $display("FAIL add_display got=%h want=%h", got, exp); else passed++;
    end
  endtask

  task automatic test_sub_neg;
    logic [15:0] got, exp;
    sb = '{16'h0, 16'd7, 16'hFFF9, 16'hFFF9, 16'd8, 16'hFFF1,
           16'h0, 16'd5, 16'd5, 16'd3, 16'd8,
           16'h0, 16'd4, 16'hFFFC, 16'hFFD6, 16'hFFD6};
    drive_seq("D7#B8C");
    total++;
    if (Result !== 16'hFFF1) $display("FAIL sub_result got=%h want=FFF1", Result); else passed++;
    drive_seq("D5A3AD4#2C");
    total++;
    if (Result !== 16'hFFD6) $display("FAIL negdigit_result got=%h want=FFD6", Result);
    else passed++;
    while (sb.size() != 0) begin
      got = obs.pop_front(); exp = sb.pop_front(); total++;
      if (got !== exp) $display("FAIL subneg_display got=%h want=%h", got, exp); else passed++;
    end
  endtask

  task automatic test_mult;
    logic [15:0] got, exp;
    int          lat;
    sb = '{16'h0, 16'd2, 16'd25, 16'd250, 16'd250, 16'd2, 16'd20, 16'd200,
           16'h0, 16'd1, 16'd12, 16'd12, 16'd3, 16'd36, 16'd4, 16'd32,
           16'h0, 16'd7, 16'hFFF9, 16'hFFF9, 16'd6, 16'hFFD6};
    drive_seq("D250*200");
    // Next key is offered the moment the equals handshake ends; it must wait out MULT.
    press("C", lat);
    press("Y", lat);
    total++;
    if (lat !== 18) $display("FAIL mult_keyrd_hold got=%0d want=18", lat); else passed++;
    repeat (20) @(posedge Clock);
    #1;
    total += 4;
    if (Result !== 16'h7FFF) $display("FAIL mult_sat_result got=%h want=7FFF", Result);
    else passed++;
    if (Display !== 16'h7FFF) $display("FAIL mult_sat_display got=%h want=7FFF", Display);
    else passed++;
    if (Overflow !== 1'b1) $display("FAIL mult_sat_ovf got=%b want=1", Overflow); else passed++;
    if (ResultValid !== 1'b1) $display("FAIL mult_valid got=%b want=1", ResultValid);
    else passed++;
    drive_seq("D12*3B4CD7#*6C");
    total += 2;
    if (Result !== 16'hFFD6) $display("FAIL mult_neg_result got=%h want=FFD6", Result);
    else passed++;
    if (Overflow !== 1'b0) $display("FAIL mult_neg_ovf got=%b want=0", Overflow); else passed++;
    while (sb.size() != 0) begin
      got = obs.pop_front(); exp = sb.pop_front(); total++;
      if (got !== exp) $display("FAIL mult_display got=%h want=%h", got, exp); else passed++;
    end
  endtask

  task automatic test_entry_limit;
    logic [15:0] got, exp;
    sb = '{16'h0, 16'd3, 16'd32, 16'd327, 16'd3276, 16'hF334, 16'h8000, 16'h7FFF,
           16'h0, 16'd3, 16'd32, 16'd327, 16'd3276, 16'h7FFF, 16'h7FFF, 16'h8001,
           16'h8001, 16'd2, 16'h8000, 16'h7FFF, 16'h0};
    drive_seq("D3276#8#");
    total++;
    if (Overflow !== 1'b1) $display("FAIL neg_min_ovf got=%b want=1", Overflow); else passed++;
    drive_seq("D327678#B2C#");
    total += 3;
    if (Result !== 16'h7FFF) $display("FAIL limit_result got=%h want=7FFF", Result);
    else passed++;
    if (Overflow !== 1'b1) $display("FAIL limit_ovf got=%b want=1", Overflow); else passed++;
    if (ResultValid !== 1'b1) $display("FAIL limit_valid got=%b want=1", ResultValid);
    else passed++;
    drive_seq("D");
    total += 3;
    if (Overflow !== 1'b0) $display("FAIL clear_ovf got=%b want=0", Overflow); else passed++;
    if (ResultValid !== 1'b0) $display("FAIL clear_valid got=%b want=0", ResultValid);
    else passed++;
    if (Result !== 16'h0) $display("FAIL clear_result got=%h want=0000", Result); else passed++;
    while (sb.size() != 0) begin
      got = obs.pop_front(); exp = sb.pop_front(); total++;
      if (got !== exp) $display("FAIL limit_display got=%h want=%h", got, exp); else passed++;
    end
  endtask

  task automatic test_ignored;
    logic [15:0] got, exp;
    int          p0;
    p0 = pulses;
    sb = '{16'h0, 16'd5, 16'd5, 16'd5, 16'd5, 16'd56, 16'd56, 16'd56};
    drive_seq("D5XYZ6CX");
    total += 3;
    if (pulses - p0 !== 8) $display("FAIL ign_pulses got=%0d want=8", pulses - p0); else passed++;
    if (ResultValid !== 1'b1) $display("FAIL ign_valid got=%b want=1", ResultValid);
    else passed++;
    if (Result !== 16'd56) $display("FAIL ign_result got=%h want=%h", Result, 16'd56);
    else passed++;
    while (sb.size() != 0) begin
      got = obs.pop_front(); exp = sb.pop_front(); total++;
      if (got !== exp) $display("FAIL ign_display got=%h want=%h", got, exp); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    string keys;
    int    lat;
    keys = "D12A3C";
    for (int i = 0; i < keys.len(); i++) begin
      press(keys[i], lat);
      total++;
      if (lat !== ((i == 0) ? 1 : 2))
        $display("FAIL b2b_latency key=%s got=%0d want=%0d", keys[i], lat, (i == 0) ? 1 : 2);
      else passed++;
    end
    repeat (4) @(posedge Clock);
    #1;
    total += 2;
    if (Display !== 16'd15) $display("FAIL b2b_display got=%h want=%h", Display, 16'd15);
    else passed++;
    if (Result !== 16'd15) $display("FAIL b2b_result got=%h want=%h", Result, 16'd15);
    else passed++;
  endtask

  task automatic test_reset_mult;
    logic [15:0] got, exp;
    int          lat;
    sb = '{16'h0, 16'd9, 16'd9, 16'd9, 16'd4, 16'd4};
    drive_seq("D9*9");
    press("C", lat);
    repeat (4) @(posedge Clock);
    test_reset("mid_mult");
    repeat (25) @(posedge Clock);
    #1;
    total++;
    if (Result !== 16'h0) $display("FAIL mult_abort_result got=%h want=0000", Result);
    else passed++;
    drive_seq("4C");
    total += 2;
    if (Result !== 16'd4) $display("FAIL post_reset_result got=%h want=0004", Result);
    else passed++;
    if (ResultValid !== 1'b1) $display("FAIL post_reset_valid got=%b want=1", ResultValid);
    else passed++;
    while (sb.size() != 0) begin
      got = obs.pop_front(); exp = sb.pop_front(); total++;
      if (got !== exp) $display("FAIL rstmult_display got=%h want=%h", got, exp); else passed++;
    end
  endtask

  initial begin
    repeat (2) @(posedge Clock);
    #1;
    test_reset("power_on");
    test_add;
    test_reset("mid_idle");
    test_sub_neg;
    test_mult;
    test_entry_limit;
    test_ignored;
    test_back_to_back;
    test_reset_mult;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
